// File: rtl/fu_issue_scheduler_pkg.sv
// fu_issue_scheduler_pkg: FU class encoding, issue-slot indices and default
// latency/CDB parameters shared by the issue scheduler.
package fu_issue_scheduler_pkg;
   typedef enum logic [2:0] {
      FU_NONE = 3'd0,
      FU_ALU  = 3'd1,
      FU_MULT = 3'd2,
      FU_LSU  = 3'd3,
      FU_BR   = 3'd4
   } fu_type_e;
   localparam int NUM_FU_CLASSES = 4;
   localparam int ISS_ALU  = 0;
   localparam int ISS_MULT = 1;
   localparam int ISS_LSU  = 2;
   localparam int ISS_BR   = 3;
   localparam int DEF_MULT_LAT  = 4;
   localparam int DEF_CDB_WIDTH = 2;
   function automatic fu_type_e slot_fu(input int s);
      return s == ISS_ALU ? FU_ALU : s == ISS_MULT ? FU_MULT :
             s == ISS_LSU ? FU_LSU : s == ISS_BR ? FU_BR : FU_NONE;
   endfunction
endpackage

// File: rtl/fu_issue_scheduler_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after
// start, wrapping modulo NUM_RS.
module rr_picker #(
   parameter int NUM_RS = 8,
   localparam int IDX_W = $clog2(NUM_RS)
) (
   input  logic [NUM_RS-1:0] req,
   input  logic [IDX_W-1:0]  start,
   output logic [NUM_RS-1:0] gnt,
   output logic [IDX_W-1:0]  idx,
   output logic              valid
);
   always_comb begin
      idx = '0;
      valid = 1'b0;
      // scanning farthest offset first lets the nearest hit overwrite earlier ones
      for (int o = NUM_RS - 1; o >= 0; o--) begin
         if (req[(int'(start) + o) % NUM_RS]) begin
            idx = IDX_W'((int'(start) + o) % NUM_RS);
            valid = 1'b1;
         end
      end
      gnt = valid ? NUM_RS'(1) << idx : '0;
   end
endmodule

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: per-class round-robin issue from the RS with CDB slot
// reservation and LSU occupancy / writeback arbitration.
module fu_issue_scheduler
   import fu_issue_scheduler_pkg::*;
#(
   parameter int NUM_RS    = 8,
   parameter int MULT_LAT  = DEF_MULT_LAT,
   parameter int CDB_WIDTH = DEF_CDB_WIDTH,
   localparam int IDX_W = $clog2(NUM_RS)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              squash,
   input  logic [NUM_RS-1:0]                 rs_valid,
   input  logic [NUM_RS-1:0]                 rs_ready,
   input  logic [NUM_RS*3-1:0]               rs_fu,
   input  logic                              lsu_result_valid,
   output logic [NUM_FU_CLASSES-1:0]         issue_valid,
   output logic [NUM_FU_CLASSES*IDX_W-1:0]   issue_idx,
   output logic [NUM_RS-1:0]                 rs_grant,
   output logic                              lsu_wb_grant,
   output logic                              lsu_busy
);
   localparam int CW = $clog2(CDB_WIDTH + 1);
   localparam logic [CW-1:0] CDB_MAX = CW'(CDB_WIDTH);
   logic [CW-1:0]     res_cnt [0:MULT_LAT];
   logic [CW-1:0]     res_nxt [0:MULT_LAT];
   logic [IDX_W-1:0]  rr_ptr  [NUM_FU_CLASSES];
   logic [NUM_RS-1:0] req     [NUM_FU_CLASSES];
   logic [NUM_RS-1:0] gnt     [NUM_FU_CLASSES];
   logic [IDX_W-1:0]  idx     [NUM_FU_CLASSES];
   logic [NUM_FU_CLASSES-1:0] found;
   logic go, adm_alu, adm_mult, adm_lsu, adm_br;
   assign go = !reset && !squash;
   always_comb begin
      for (int c = 0; c < NUM_FU_CLASSES; c++)
         for (int i = 0; i < NUM_RS; i++)
            req[c][i] = rs_valid[i] & rs_ready[i] & (rs_fu[3*i +: 3] == 3'(slot_fu(c)));
   end
   for (genvar c = 0; c < NUM_FU_CLASSES; c++) begin : g_pick
      rr_picker #(.NUM_RS(NUM_RS)) u_pick (
         .req(req[c]), .start(rr_ptr[c]), .gnt(gnt[c]), .idx(idx[c]), .valid(found[c]));
   end
   assign lsu_wb_grant = go & lsu_result_valid & (res_cnt[0] < CDB_MAX);
   // BR claims the shared latency-1 slot before ALU
   assign adm_br   = go & found[ISS_BR] & (res_cnt[1] < CDB_MAX);
   assign adm_alu  = go & found[ISS_ALU] & (res_cnt[1] < CDB_MAX - CW'(adm_br));
   assign adm_mult = go & found[ISS_MULT] & (res_cnt[MULT_LAT] < CDB_MAX);
   assign adm_lsu  = go & found[ISS_LSU] & (!lsu_busy | lsu_wb_grant);
   always_comb begin
      issue_valid = '0;
      issue_valid[ISS_ALU] = adm_alu;
      issue_valid[ISS_MULT] = adm_mult;
      issue_valid[ISS_LSU] = adm_lsu;
      issue_valid[ISS_BR] = adm_br;
      rs_grant = '0;
      issue_idx = '0;
      for (int c = 0; c < NUM_FU_CLASSES; c++) begin
         rs_grant = rs_grant | (issue_valid[c] ? gnt[c] : '0);
         issue_idx[c*IDX_W +: IDX_W] = issue_valid[c] ? idx[c] : '0;
      end
   end
   always_comb begin
      for (int k = 0; k < MULT_LAT; k++)
         res_nxt[k] = res_cnt[k+1] + (k == 0 ? CW'(adm_alu) + CW'(adm_br) : '0)
                    + (k == MULT_LAT - 1 ? CW'(adm_mult) : '0);
      res_nxt[MULT_LAT] = '0;
   end
   always_ff @(posedge clock) begin
      for (int k = 0; k <= MULT_LAT; k++)
         assert (reset || res_cnt[k] <= CDB_MAX);
      if (reset || squash) begin
         for (int k = 0; k <= MULT_LAT; k++) res_cnt[k] <= '0;
         for (int c = 0; c < NUM_FU_CLASSES; c++) rr_ptr[c] <= '0;
         lsu_busy <= 1'b0;
      end else begin
         res_cnt <= res_nxt;
         for (int c = 0; c < NUM_FU_CLASSES; c++)
            if (issue_valid[c]) rr_ptr[c] <= idx[c] == IDX_W'(NUM_RS - 1) ? '0 : idx[c] + 1'b1;
         lsu_busy <= adm_lsu ? 1'b1 : lsu_wb_grant ? 1'b0 : lsu_busy;
      end
   end
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed scenarios then random traffic, checked against
// a model that books CDB usage per absolute completion cycle.
module tb_fu_issue_scheduler;
   logic        clock = 1'b0;
   logic        reset, squash, lsu_result_valid;
   logic [7:0]  rs_valid, rs_ready;
   logic [23:0] rs_fu;
   logic [3:0]  issue_valid;
   logic [11:0] issue_idx;
   logic [7:0]  rs_grant;
   logic        lsu_wb_grant, lsu_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int occ [int];
   int mptr [4];
   bit mbusy;
   logic [3:0]  l_valid;
   logic [11:0] l_idx;
   logic [7:0]  l_grant;
   logic        l_wb, l_busy;

   always #5 clock = ~clock;

   fu_issue_scheduler dut (
      .clock(clock), .reset(reset), .squash(squash),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_fu(rs_fu),
      .lsu_result_valid(lsu_result_valid),
      .issue_valid(issue_valid), .issue_idx(issue_idx), .rs_grant(rs_grant),
      .lsu_wb_grant(lsu_wb_grant), .lsu_busy(lsu_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int occ_at(input int t);
      return occ.exists(t) ? occ[t] : 0;
   endfunction

   task automatic clr_rs();
      rs_valid = '0;
      rs_ready = '0;
      rs_fu = '0;
   endtask

   task automatic put(input int j, input logic [2:0] fu);
      rs_valid[j] = 1'b1;
      rs_ready[j] = 1'b1;
      rs_fu[3*j +: 3] = fu;
   endtask

   // One cycle: predict from the model, compare mid-cycle, then advance the model.
   task automatic tick();
      bit go, e_wb;
      bit fnd [4];
      bit ok [4];
      int pick [4];
      int lat1;
      logic [3:0]  e_valid;
      logic [11:0] e_idx;
      logic [7:0]  e_grant;
      @(negedge clock);
      go = !squash;
      e_wb = go && lsu_result_valid && occ_at(cyc) < 2;
      for (int c = 0; c < 4; c++) begin
         fnd[c] = 0;
         pick[c] = 0;
         for (int o = 0; o < 8; o++) begin
            int j;
            j = (mptr[c] + o) % 8;
            if (!fnd[c] && rs_valid[j] && rs_ready[j] && int'(rs_fu[3*j +: 3]) == c + 1) begin
               fnd[c] = 1;
               pick[c] = j;
            end
         end
      end
      lat1 = occ_at(cyc + 1);
      ok[3] = go && fnd[3] && lat1 < 2;
      if (ok[3]) lat1++;
      ok[0] = go && fnd[0] && lat1 < 2;
      ok[1] = go && fnd[1] && occ_at(cyc + 4) < 2;
      ok[2] = go && fnd[2] && (!mbusy || e_wb);
      e_valid = '0;
      e_idx = '0;
      e_grant = '0;
      for (int c = 0; c < 4; c++) begin
         e_valid[c] = ok[c];
         e_idx[3*c +: 3] = ok[c] ? 3'(pick[c]) : 3'd0;
         e_grant = e_grant | (ok[c] ? 8'd1 << pick[c] : 8'd0);
      end
      l_valid = issue_valid;
      l_idx = issue_idx;
      l_grant = rs_grant;
      l_wb = lsu_wb_grant;
      l_busy = lsu_busy;
      chk("issue_valid", 32'(issue_valid), 32'(e_valid));
      chk("issue_idx", 32'(issue_idx), 32'(e_idx));
      chk("rs_grant", 32'(rs_grant), 32'(e_grant));
      chk("lsu_wb_grant", 32'(lsu_wb_grant), 32'(e_wb));
      chk("lsu_busy", 32'(lsu_busy), 32'(mbusy));
      @(posedge clock);
      if (squash) begin
         occ.delete();
         for (int c = 0; c < 4; c++) mptr[c] = 0;
         mbusy = 0;
      end else begin
         if (ok[3]) occ[cyc + 1] = occ_at(cyc + 1) + 1;
         if (ok[0]) occ[cyc + 1] = occ_at(cyc + 1) + 1;
         if (ok[1]) occ[cyc + 4] = occ_at(cyc + 4) + 1;
         for (int c = 0; c < 4; c++) if (ok[c]) mptr[c] = (pick[c] + 1) % 8;
         mbusy = ok[2] ? 1 : e_wb ? 0 : mbusy;
      end
      cyc++;
      #1;
   endtask

   initial begin
      int rr_exp [4];
      rr_exp = '{1, 4, 6, 1};
      reset = 1'b1;
      squash = 1'b0;
      lsu_result_valid = 1'b1;
      clr_rs();
      put(1, 3'd1);
      put(3, 3'd3);
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_valid", 32'(issue_valid), 32'd0);
      chk("reset_grant", 32'(rs_grant), 32'd0);
      chk("reset_wb", 32'(lsu_wb_grant), 32'd0);
      chk("reset_busy", 32'(lsu_busy), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      lsu_result_valid = 1'b0;
      clr_rs();
      for (int c = 0; c < 4; c++) mptr[c] = 0;
      mbusy = 0;
      repeat (3) tick();

      put(1, 3'd1); put(4, 3'd1); put(6, 3'd1);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("rr_alu_idx", 32'(l_idx[2:0]), 32'(rr_exp[n]));
      end

      clr_rs(); put(0, 3'd2);
      tick();
      chk("cdb_mult_issue", 32'(l_valid), 32'b0010);
      clr_rs();
      repeat (2) tick();
      put(2, 3'd4); put(5, 3'd1);
      tick();
      chk("cdb_br_only", 32'(l_valid), 32'b1000);
      clr_rs(); put(5, 3'd1);
      tick();
      chk("cdb_alu_later", 32'(l_valid), 32'b0001);

      clr_rs(); put(3, 3'd3); put(1, 3'd1); put(2, 3'd4);
      tick();
      chk("lsu_first", 32'(l_valid), 32'b1101);
      clr_rs(); put(7, 3'd3); put(1, 3'd1);
      lsu_result_valid = 1'b1;
      tick();
      chk("lsu_wb_denied", 32'(l_wb), 32'd0);
      chk("lsu_blocked", 32'(l_valid), 32'b0001);
      tick();
      chk("lsu_wb_ok", 32'(l_wb), 32'd1);
      chk("lsu_b2b_valid", 32'(l_valid), 32'b0101);
      chk("lsu_b2b_idx", 32'(l_idx[8:6]), 32'd7);

      lsu_result_valid = 1'b0;
      clr_rs(); put(0, 3'd2); put(1, 3'd1);
      tick();
      chk("sq_busy_before", 32'(l_busy), 32'd1);
      clr_rs();
      tick();
      put(1, 3'd1); put(6, 3'd1); put(3, 3'd3); put(4, 3'd4);
      lsu_result_valid = 1'b1;
      squash = 1'b1;
      tick();
      chk("sq_valid", 32'(l_valid), 32'd0);
      chk("sq_grant", 32'(l_grant), 32'd0);
      chk("sq_wb", 32'(l_wb), 32'd0);
      squash = 1'b0;
      lsu_result_valid = 1'b0;
      tick();
      chk("sq_busy_after", 32'(l_busy), 32'd0);
      chk("sq_ptr_reset", 32'(l_idx[2:0]), 32'd1);
      chk("sq_res_clear", 32'(l_valid), 32'b1101);

      clr_rs();
      put(0, 3'd0); put(1, 3'd1); put(2, 3'd5); put(3, 3'd6); put(4, 3'd7);
      tick();
      chk("illegal_grant", 32'(l_grant), 32'b0000_0010);

      for (int n = 0; n < 600; n++) begin
         for (int j = 0; j < 8; j++) begin
            rs_valid[j] = $urandom_range(0, 3) != 0;
            rs_ready[j] = $urandom_range(0, 2) != 0;
            rs_fu[3*j +: 3] = $urandom_range(0, 9) < 8 ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
         end
         lsu_result_valid = $urandom_range(0, 2) == 0;
         squash = $urandom_range(0, 29) == 0;
         tick();
      end
      squash = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
